// File: rtl/midi_byte_receiver.sv
// MIDI 8N1 serial-to-byte receiver with valid/ready output, framing-error and
// overrun pulses, and a busy flag for merge arbitration.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   WAIT_IDLE | after reset or framing error; wait for a real idle-high line
//   IDLE      | line idle; a low rx_s starts a frame
//   START     | timing to mid start bit; high there means a glitch
//   DATA      | sampling 8 data bits, LSB first, one per bit period
//   STOP      | sampling the stop bit; deliver byte or flag framing error
module midi_byte_receiver #(
   parameter int CLKS_PER_BIT = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       midi_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_frame_err,
   output logic       rx_overrun,
   output logic       rx_busy
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_TC = CW'(HALF - 1);
   localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;

   state_t        state, state_nxt;
   logic          rx_m, rx_s;
   logic [1:0]    sync_vld;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]    idx, idx_nxt;
   logic [7:0]    shreg, shreg_nxt;
   logic          stop_ok, stop_bad;

   // sync_vld marks when rx_s reflects the real line rather than the reset
   // value, so a line held low across reset is never mistaken for idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m     <= 1'b1;
         rx_s     <= 1'b1;
         sync_vld <= 2'b00;
      end else begin
         rx_m     <= midi_rx;
         rx_s     <= rx_m;
         sync_vld <= {sync_vld[0], 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= WAIT_IDLE;
         cnt   <= '0;
         idx   <= 3'd0;
         shreg <= 8'h00;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
         shreg <= shreg_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CW'(1);
      idx_nxt   = idx;
      shreg_nxt = shreg;
      stop_ok   = 1'b0;
      stop_bad  = 1'b0;
      case (state)
         WAIT_IDLE: begin
            cnt_nxt = '0;
            if (sync_vld[1] && rx_s) state_nxt = IDLE;
         end
         IDLE: begin
            cnt_nxt = '0;
            if (!rx_s) state_nxt = START;
         end
         START: begin
            if (cnt == HALF_TC) begin
               cnt_nxt = '0;
               if (rx_s) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt = DATA;
                  idx_nxt   = 3'd0;
               end
            end
         end
         DATA: begin
            if (cnt == BIT_TC) begin
               cnt_nxt        = '0;
               shreg_nxt[idx] = rx_s;
               if (idx == 3'd7) state_nxt = STOP;
               else             idx_nxt   = idx + 3'd1;
            end
         end
         STOP: begin
            if (cnt == BIT_TC) begin
               cnt_nxt = '0;
               if (rx_s) begin
                  stop_ok   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  stop_bad  = 1'b1;
                  state_nxt = WAIT_IDLE;
               end
            end
         end
         default: state_nxt = WAIT_IDLE;
      endcase
   end

   // A byte may land in the same cycle the previous one is consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data      <= 8'h00;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
         rx_overrun   <= 1'b0;
      end else begin
         rx_frame_err <= stop_bad;
         rx_overrun   <= 1'b0;
         if (stop_ok) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= shreg;
               rx_valid <= 1'b1;
            end else begin
               rx_overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

   assign rx_busy = (state == START) || (state == DATA) || (state == STOP);

endmodule

// File: tb/tb_midi_byte_receiver.sv
// Bench for midi_byte_receiver: directed MIDI frames, expected bytes queued
// with their delivery cycle and checked by an independent monitor.
module tb_midi_byte_receiver;

   localparam int CPB  = 32;
   localparam int HALF = CPB / 2;
   localparam int DELIVER_OFS = 2 + HALF + 9 * CPB + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       midi_rx;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       rx_overrun;
   logic       rx_busy;

   always #5 clk = ~clk;

   midi_byte_receiver #(.CLKS_PER_BIT(CPB)) dut (
      .clk          (clk),
      .rst          (rst),
      .midi_rx      (midi_rx),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .rx_frame_err (rx_frame_err),
      .rx_overrun   (rx_overrun),
      .rx_busy      (rx_busy)
   );

   typedef struct {
      logic [7:0] data;
      int         at;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cycle = 0;
   int   err_cnt = 0;
   int   ovr_cnt = 0;
   int   busy_cnt = 0;
   logic prev_valid = 1'b0;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: a new byte is presented when rx_valid rises or is reloaded in a
   // handshake cycle.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rx_frame_err) err_cnt++;
      if (rx_overrun)   ovr_cnt++;
      if (rx_busy)      busy_cnt++;
      if (rx_valid && (!prev_valid || rx_ready)) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL byte_unexpected: got 0x%02h at cycle %0d, expected none", rx_data, cycle);
         end else begin
            e = exp_q.pop_front();
            if (rx_data !== e.data || cycle != e.at) begin
               fails++;
               $display("FAIL byte_rx: got 0x%02h at cycle %0d, expected 0x%02h at cycle %0d",
                        rx_data, cycle, e.data, e.at);
            end
         end
      end
      prev_valid = rx_valid;
   end

   task automatic drive_bit(input logic v, input int n);
      repeat (n) begin
         @(negedge clk);
         midi_rx = v;
      end
   endtask

   // ready_at >= 0 pulses rx_ready only in that cycle of the frame (cycle 0 =
   // first edge sampling the start bit).
   task automatic send_frame(input logic [7:0] b, input logic stop, input int ready_at,
                             input logic deliver);
      logic [9:0] bits;
      exp_t e;
      bits = {stop, b, 1'b0};
      for (int n = 0; n < 10 * CPB; n++) begin
         @(negedge clk);
         midi_rx = bits[n / CPB];
         if (ready_at >= 0) rx_ready = (n == ready_at);
         if (n == 0 && deliver) begin
            e.data = b;
            e.at   = cycle + DELIVER_OFS;
            exp_q.push_back(e);
         end
      end
   endtask

   initial begin
      int b0, e0, o0;
      rst      = 1'b1;
      midi_rx  = 1'b1;
      rx_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_data",  {24'd0, rx_data}, 32'h00);
      check("reset_valid", {31'd0, rx_valid}, 32'd0);
      check("reset_ferr",  {31'd0, rx_frame_err}, 32'd0);
      check("reset_ovr",   {31'd0, rx_overrun}, 32'd0);
      check("reset_busy",  {31'd0, rx_busy}, 32'd0);
      drive_bit(1'b1, 40);

      // Clean frame, ready held high
      rx_ready = 1'b1;
      b0 = busy_cnt; e0 = err_cnt; o0 = ovr_cnt;
      send_frame(8'h90, 1'b1, -1, 1'b1);
      drive_bit(1'b1, CPB);
      check("t1_busy_cycles", busy_cnt - b0, 32'd304);
      check("t1_ferr", err_cnt - e0, 32'd0);
      check("t1_ovr",  ovr_cnt - o0, 32'd0);
      check("t1_valid_low", {31'd0, rx_valid}, 32'd0);

      // Short low glitch on the idle line
      b0 = busy_cnt; e0 = err_cnt; o0 = ovr_cnt;
      drive_bit(1'b0, 4);
      drive_bit(1'b1, 3 * CPB);
      check("t2_busy_cycles", busy_cnt - b0, 32'd16);
      check("t2_busy_now", {31'd0, rx_busy}, 32'd0);
      check("t2_ferr", err_cnt - e0, 32'd0);
      check("t2_ovr",  ovr_cnt - o0, 32'd0);
      check("t2_valid", {31'd0, rx_valid}, 32'd0);

      // Framing error, line held low, then a good frame
      e0 = err_cnt; o0 = ovr_cnt;
      send_frame(8'h00, 1'b0, -1, 1'b0);
      drive_bit(1'b0, 2 * CPB);
      drive_bit(1'b1, CPB);
      send_frame(8'h3C, 1'b1, -1, 1'b1);
      drive_bit(1'b1, CPB);
      check("t3_ferr", err_cnt - e0, 32'd1);
      check("t3_ovr",  ovr_cnt - o0, 32'd0);

      // Back-to-back frames with consumer stalled
      rx_ready = 1'b0;
      e0 = err_cnt; o0 = ovr_cnt;
      send_frame(8'h90, 1'b1, -1, 1'b1);
      send_frame(8'h3C, 1'b1, -1, 1'b0);
      send_frame(8'h7F, 1'b1, -1, 1'b0);
      drive_bit(1'b1, CPB);
      check("t4_ovr",   ovr_cnt - o0, 32'd2);
      check("t4_ferr",  err_cnt - e0, 32'd0);
      check("t4_data",  {24'd0, rx_data}, 32'h90);
      check("t4_valid", {31'd0, rx_valid}, 32'd1);
      @(negedge clk);
      rx_ready = 1'b1;
      @(posedge clk);
      #1;
      check("t4_valid_drop", {31'd0, rx_valid}, 32'd0);
      check("t4_data_hold",  {24'd0, rx_data}, 32'h90);
      @(negedge clk);
      rx_ready = 1'b0;
      drive_bit(1'b1, CPB);

      // Consume exactly in the stop-sample cycle of the next frame
      o0 = ovr_cnt;
      send_frame(8'h90, 1'b1, -1, 1'b1);
      drive_bit(1'b1, CPB);
      send_frame(8'h45, 1'b1, DELIVER_OFS - 1, 1'b1);
      drive_bit(1'b1, CPB);
      check("t5_ovr",   ovr_cnt - o0, 32'd0);
      check("t5_valid", {31'd0, rx_valid}, 32'd1);
      check("t5_data",  {24'd0, rx_data}, 32'h45);

      // Reset in the middle of bit 4 with the line low; held 0x45 is dropped
      e0 = err_cnt; o0 = ovr_cnt;
      drive_bit(1'b0, 5 * CPB + HALF);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t6_data",  {24'd0, rx_data}, 32'h00);
      check("t6_valid", {31'd0, rx_valid}, 32'd0);
      check("t6_ferr",  {31'd0, rx_frame_err}, 32'd0);
      check("t6_ovr",   {31'd0, rx_overrun}, 32'd0);
      check("t6_busy",  {31'd0, rx_busy}, 32'd0);
      b0 = busy_cnt;
      drive_bit(1'b0, 3 * CPB);
      check("t6_no_start_low", busy_cnt - b0, 32'd0);
      drive_bit(1'b1, 2 * CPB);
      rx_ready = 1'b1;
      send_frame(8'hF8, 1'b1, -1, 1'b1);
      drive_bit(1'b1, CPB);
      check("t6_ferr_total", err_cnt - e0, 32'd0);
      check("t6_ovr_total",  ovr_cnt - o0, 32'd0);

      check("queue_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      fails++;
      $display("FAIL watchdog: simulation did not complete, expected completion before 2 ms");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

endmodule
